add_n_sgn_pipe: RTL and testbench
=================================

# add_n_sgn_pipe

Pipelined, parametrised N-operand signed adder/subtractor with a valid/ready stream interface on both sides. It is the next generation of the team's fixed three-operand signed adder. It adds a per-operand subtract mask, configurable operand count and width, two register stages and backpressure. It sits in datapath benchmarks wherever multi-operand signed sums must be streamed at one result per cycle.

## Interface
Parameters:
- `BW`, 8, operand width in bits (two's complement); legal values are ≥2.
- `N`, 3, number of operands; legal values are ≥2.
- `SW`, localparam, result width, equal to `BW + $clog2(N+1)`. This is exact for any mix of add and subtract, including negation of -2^(BW-1).

Ports (clock and reset first):
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous active-high reset.
- `in_valid`, in, 1: the input operand set is valid.
- `in_ready`, out, 1: the block can accept an input this cycle.
- `in_ops`, in, N*BW: operand i is at `[i*BW +: BW]`, signed.
- `in_sub`, in, N: bit i=1 makes operand i subtracted.
- `out_valid`, out, 1: the result is valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_sum`, out, SW: signed result.
- `out_ovf`, out, 1: saturation occurred. This is meaningful only with the macro defined.

## Operation
- Accept: a transfer occurs on a cycle with `in_valid && in_ready`. The output transfer occurs on `out_valid && out_ready`.
- Stage S1 (registered on accept): each term t_i = in_sub[i] ? -sext(op_i) : sext(op_i), computed in SW bits. All N terms and the S1 valid bit are registered.
- Stage S2: the sum of all S1 terms, in SW bits, is registered into `out_sum`, together with the S2 valid bit. With SAT_EN, clamp and ovf are applied before this register.
- Arithmetic: the SW-bit result never wraps; the result is exact for every input.
- Advance rules:
  - S2 loads when `!s2_valid || out_ready`.
  - S1 loads when `!s1_valid || s2 loads`.
  - `in_ready` = S1 loads, a combinational function of the valid bits and `out_ready`.
- Simultaneous events: a full pipe with `out_ready=1` accepts a new input and emits a result in the same cycle, with no bubble.
- Hold: while `out_valid && !out_ready`:
  - `out_sum` and `out_ovf` are held stable.
  - S1 fills.
  - `in_ready` drops once S1 is also valid.
- Order: results emerge in acceptance order; no transaction is dropped or duplicated.
- Reset: while `rst` is high, `in_ready`=0. On the clocked reset, the following all go to 0:
  - `s1_valid`
  - `out_valid`
  - `out_sum`
  - `out_ovf`

  Transactions in flight when reset is asserted mid-operation are discarded.

## Timing
- Latency: 2 cycles. An input accepted at edge k produces `out_valid`=1 after edge k+1, so it is visible in the cycle following edge k+1, provided `out_ready` was not stalling.
- Throughput: 1 result per cycle with `out_ready` held high.
- Buffer capacity: 2 transactions, one in S1 and one in S2.
- Reset values: `out_valid`=0, `out_sum`=0, `out_ovf`=0, `in_ready`=0 during reset and 1 in the first cycle after reset.
- `in_ready` depends combinationally on `out_ready`. No other combinational input-to-output path exists.

## Configuration
- Macro: `ADD_N_SGN_PIPE_SAT_EN`.
- Defined: the S2 sum is clamped to the BW-bit range [-2^(BW-1), 2^(BW-1)-1], then sign-extended to SW. `out_ovf`=1 when clamping occurred, registered with the result.
- Undefined: `out_sum` is the exact SW-bit sum and `out_ovf` is tied to 0.
- Port list and latency are identical in both builds.

## Test plan
- BW=8, N=3, ops {127,127,127}, sub=000, `out_ready`=1:
  - Macro undefined: `out_sum`=381, `out_ovf`=0, exactly 2 cycles after accept.
  - Macro defined: `out_sum`=127, `out_ovf`=1.
- BW=8, N=3, ops {-128,-128,-128}, sub=111: `out_sum`=+384 with the macro undefined. With the macro defined, `out_sum`=127 and `out_ovf`=1.
- Backpressure: `out_ready`=0, then offer 3 back-to-back inputs {1,2,3} (sub=000 each):
  - Exactly 2 are accepted; `in_ready`=0 on the third.
  - `out_sum`=6 is held stable for 5 cycles.
  - After releasing `out_ready`, results 6, then the second sum, then the third, emerge in order.
- Streaming: 200 random inputs with random sub masks, `in_valid` and `out_ready` held high. The bench requires one accept and one result per cycle after fill, and every result must match the reference model.
- Reset mid-operation: with 2 transactions in flight, assert `rst` for 1 cycle. The next cycle must show `out_valid`=0, `out_sum`=0 and no stale result emitted. The first result after reset must be the post-reset input's sum.
- BW=4, N=2, ops {-8, 7}, sub=10: `out_sum`=+15 (SW=6), with `out_ovf`=0 when the macro is undefined.

Source files
------------

// File: rtl/add_n_sgn_pipe.sv
// add_n_sgn_pipe: two-stage pipelined N-operand signed adder/subtractor
// with valid/ready handshakes on both sides.
//   S1: sign-extends each operand to SW bits and negates it when its
//       subtract bit is set.
//   S2: sums all S1 terms and registers the result.
// Optional build macro ADD_N_SGN_PIPE_SAT_EN clamps the S2 sum to the
// BW-bit signed range and flags the clamp on out_ovf. Without it, the
// exact SW-bit sum is produced and out_ovf stays 0.
module add_n_sgn_pipe #(
    parameter int BW = 8,
    parameter int N  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*BW-1:0]           in_ops,
    input  logic [N-1:0]              in_sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BW+$clog2(N+1)-1:0] out_sum,
    output logic                      out_ovf
);

    // SW bits hold N terms of magnitude up to 2^(BW-1) without wrapping.
    localparam int SW = BW + $clog2(N + 1);

`ifdef ADD_N_SGN_PIPE_SAT_EN
    // Largest BW-bit signed value, sign-extended to SW bits. Its bitwise
    // complement is the most negative BW-bit value.
    localparam logic [SW-1:0] SAT_MAX = {{(SW-BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic          s1_valid_r;
    logic [SW-1:0] s1_term_r [N];
    logic [SW-1:0] ext_s     [N];
    logic [SW-1:0] term_s    [N];
    logic [SW-1:0] sum_s;
    logic [SW-1:0] sat_sum_s;
    logic          ovf_s;
    logic          s1_load_s;
    logic          s2_load_s;
    logic          accept_s;

    // Handshake: each stage advances when it is empty or its successor
    // advances. Reset gates in_ready so nothing is accepted during reset.
    always_comb begin
        s2_load_s = !out_valid || out_ready;
        s1_load_s = !s1_valid_r || s2_load_s;
        in_ready  = s1_load_s && !rst;
        accept_s  = in_valid && in_ready;
    end

    // S1 term formation: sign-extend each operand, then negate if selected.
    // Negation is exact because SW > BW, so -(-2^(BW-1)) is representable.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ext_s[i] = SW'($signed(in_ops[i*BW +: BW]));
            if (in_sub[i]) begin
                term_s[i] = -ext_s[i];
            end else begin
                term_s[i] = ext_s[i];
            end
        end
    end

    // S1 register: captures the terms of each accepted operand set.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                s1_term_r[i] <= {SW{1'b0}};
            end
        end else if (s1_load_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_term_r <= term_s;
            end
        end
    end

    // S2 sum of all registered terms. Modular SW-bit addition equals the
    // exact signed sum because every partial sum fits in SW bits.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < N; i++) begin
            sum_s = sum_s + s1_term_r[i];
        end
    end

    // Optional clamp of the sum to the BW-bit signed range.
    always_comb begin
`ifdef ADD_N_SGN_PIPE_SAT_EN
        if ($signed(sum_s) > $signed(SAT_MAX)) begin
            sat_sum_s = SAT_MAX;
            ovf_s     = 1'b1;
        end else if ($signed(sum_s) < $signed(SAT_MIN)) begin
            sat_sum_s = SAT_MIN;
            ovf_s     = 1'b1;
        end else begin
            sat_sum_s = sum_s;
            ovf_s     = 1'b0;
        end
`else
        sat_sum_s = sum_s;
        ovf_s     = 1'b0;
`endif
    end

    // S2 register: result, overflow flag and output valid. Held stable while
    // downstream stalls; loaded only with real data so bubbles keep the
    // last result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= {SW{1'b0}};
            out_ovf   <= 1'b0;
        end else if (s2_load_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_sum <= sat_sum_s;
                out_ovf <= ovf_s;
            end
        end
    end

endmodule

// File: tb/tb_add_n_sgn_pipe.sv
// Directed self-checking bench for add_n_sgn_pipe. Instantiates a BW=8,N=3
// unit for the main scenarios and a BW=4,N=2 unit for the narrow case.
// Expected values follow the ADD_N_SGN_PIPE_SAT_EN build setting.
module tb_add_n_sgn_pipe;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [23:0] in_ops    = 24'd0;
    logic [2:0]  in_sub    = 3'd0;
    logic        in_ready;
    logic        out_valid;
    logic [9:0]  out_sum;
    logic        out_ovf;

    logic        in_valid4  = 1'b0;
    logic        out_ready4 = 1'b1;
    logic [7:0]  in_ops4    = 8'd0;
    logic [1:0]  in_sub4    = 2'd0;
    logic        in_ready4;
    logic        out_valid4;
    logic [5:0]  out_sum4;
    logic        out_ovf4;

    int n_cmp  = 0;
    int n_fail = 0;

    add_n_sgn_pipe #(.BW(8), .N(3)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    add_n_sgn_pipe #(.BW(4), .N(2)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_ops(in_ops4), .in_sub(in_sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sum(out_sum4), .out_ovf(out_ovf4)
    );

    always #5 clk = ~clk;

    // Operands listed most-significant first: {op2, op1, op0}.
    task automatic set_ops3(input int a2, input int a1, input int a0);
        logic [7:0] b2, b1, b0;
        b2 = 8'(a2); b1 = 8'(a1); b0 = 8'(a0);
        in_ops = {b2, b1, b0};
    endtask

    // Reference: integer sum with optional clamp to [-128,127].
    function automatic void model3(input logic [23:0] ops, input logic [2:0] sub,
                                   output int s, output bit o);
        int v;
        s = 0;
        o = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = int'($signed(ops[i*8 +: 8]));
            s = sub[i] ? s - v : s + v;
        end
`ifdef ADD_N_SGN_PIPE_SAT_EN
        if (s > 127) begin s = 127; o = 1'b1; end
        else if (s < -128) begin s = -128; o = 1'b1; end
`endif
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_sum !== 10'd0) begin n_fail++; $display("FAIL rst_out_sum got=%0d want=0", out_sum); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_out_ovf got=%b want=0", out_ovf); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_max_pos;
        int got, want; bit wo;
`ifdef ADD_N_SGN_PIPE_SAT_EN
        want = 127; wo = 1'b1;
`else
        want = 381; wo = 1'b0;
`endif
        @(negedge clk);
        out_ready = 1'b1; set_ops3(127, 127, 127); in_sub = 3'b000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL maxpos_early got=%b want=0", out_valid); end
        @(negedge clk);
        got = int'($signed(out_sum));
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL maxpos_valid got=%b want=1", out_valid); end
        n_cmp++; if (got !== want) begin n_fail++; $display("FAIL maxpos_sum got=%0d want=%0d", got, want); end
        n_cmp++; if (out_ovf !== wo) begin n_fail++; $display("FAIL maxpos_ovf got=%b want=%b", out_ovf, wo); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL maxpos_single got=%b want=0", out_valid); end
    endtask

    task automatic test_neg_sub;
        int got, want; bit wo;
`ifdef ADD_N_SGN_PIPE_SAT_EN
        want = 127; wo = 1'b1;
`else
        want = 384; wo = 1'b0;
`endif
        @(negedge clk);
        set_ops3(-128, -128, -128); in_sub = 3'b111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        got = int'($signed(out_sum));
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL negsub_valid got=%b want=1", out_valid); end
        n_cmp++; if (got !== want) begin n_fail++; $display("FAIL negsub_sum got=%0d want=%0d", got, want); end
        n_cmp++; if (out_ovf !== wo) begin n_fail++; $display("FAIL negsub_ovf got=%b want=%b", out_ovf, wo); end
    endtask

    task automatic test_backpressure;
        int acc;
        int got;
        acc = 0;
        @(negedge clk);
        out_ready = 1'b0; set_ops3(3, 2, 1); in_sub = 3'b000; in_valid = 1'b1;
        #1; if (in_ready) acc++;
        @(negedge clk);
        set_ops3(6, 5, 4);
        #1; if (in_ready) acc++;
        @(negedge clk);
        set_ops3(30, 20, 10);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_third_ready got=%b want=0", in_ready); end
        if (in_ready) acc++;
        n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL bp_accepts got=%0d want=2", acc); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            got = int'($signed(out_sum));
            n_cmp++; if (out_valid !== 1'b1 || got !== 6 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d valid=%b sum=%0d rdy=%b want 1/6/0", k, out_valid, got, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        got = int'($signed(out_sum));
        n_cmp++; if (out_valid !== 1'b1 || got !== 6 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release valid=%b sum=%0d rdy=%b want 1/6/1", out_valid, got, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        got = int'($signed(out_sum));
        n_cmp++; if (out_valid !== 1'b1 || got !== 15) begin n_fail++; $display("FAIL bp_second valid=%b sum=%0d want 1/15", out_valid, got); end
        @(negedge clk);
        got = int'($signed(out_sum));
        n_cmp++; if (out_valid !== 1'b1 || got !== 60) begin n_fail++; $display("FAIL bp_third valid=%b sum=%0d want 1/60", out_valid, got); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_stream;
        int exp_q[$];
        bit ovf_q[$];
        int s, got, e;
        bit o, eo;
        out_ready = 1'b1;
        for (int k = 0; k < 202; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid k=%0d got=%b want=1", k, out_valid); end
            end
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++; $display("FAIL stream_extra k=%0d got=result want=none", k);
                end else begin
                    e = exp_q.pop_front(); eo = ovf_q.pop_front();
                    got = int'($signed(out_sum));
                    n_cmp++; if (got !== e || out_ovf !== eo) begin
                        n_fail++; $display("FAIL stream_data k=%0d sum=%0d ovf=%b want %0d/%b", k, got, out_ovf, e, eo);
                    end
                end
            end
            if (k < 200) begin
                in_ops = 24'($urandom()); in_sub = 3'($urandom()); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k < 200) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready k=%0d got=%b want=1", k, in_ready); end
                if (in_ready === 1'b1) begin
                    model3(in_ops, in_sub, s, o);
                    exp_q.push_back(s); ovf_q.push_back(o);
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int got, s;
        bit o;
        bit seen;
        @(negedge clk);
        out_ready = 1'b0; set_ops3(1, 1, 1); in_sub = 3'b000; in_valid = 1'b1;
        @(negedge clk);
        set_ops3(9, 9, 9);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got=%b want=0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || out_sum !== 10'd0) begin
            n_fail++; $display("FAIL rstmid_clear valid=%b sum=%0d want 0/0", out_valid, out_sum);
        end
        set_ops3(-5, 40, 7); in_sub = 3'b010; in_valid = 1'b1;
        model3(in_ops, in_sub, s, o);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale got=%b want=0", out_valid); end
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                got = int'($signed(out_sum));
                n_cmp++; if (got !== s) begin n_fail++; $display("FAIL rstmid_first got=%0d want=%0d", got, s); end
            end
        end
        if (!seen) begin n_cmp++; n_fail++; $display("FAIL rstmid_timeout got=no result want=result"); end
    endtask

    task automatic test_bw4;
        int got, want; bit wo;
`ifdef ADD_N_SGN_PIPE_SAT_EN
        want = 7; wo = 1'b1;
`else
        want = 15; wo = 1'b0;
`endif
        @(negedge clk);
        in_ops4 = {4'h8, 4'h7}; in_sub4 = 2'b10; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        @(negedge clk);
        got = int'($signed(out_sum4));
        n_cmp++; if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL bw4_valid got=%b want=1", out_valid4); end
        n_cmp++; if (got !== want) begin n_fail++; $display("FAIL bw4_sum got=%0d want=%0d", got, want); end
        n_cmp++; if (out_ovf4 !== wo) begin n_fail++; $display("FAIL bw4_ovf got=%b want=%b", out_ovf4, wo); end
    endtask

    initial begin
        test_reset();
        test_max_pos();
        test_neg_sub();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_bw4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
